// File: rtl/skinny_sbox_pkg.sv
// Shared definitions for the masked, iterative inverse SKINNY-128 8-bit S-box:
// FSM encoding, layer count and the per-layer inverse bit permutations.
package skinny_sbox_pkg;

    localparam int unsigned N_LAYERS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Packed source indices, 3 bits per output bit: out[i] = in[IDX[3*i +: 3]].
    // Layer 0 undoes the final bit-1/bit-2 swap; layers 1..3 undo the full permutation.
    localparam logic [23:0] INV_SWAP_IDX = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd1, 3'd2, 3'd0};
    localparam logic [23:0] INV_P_IDX    = {3'd5, 3'd4, 3'd0, 3'd3, 3'd1, 3'd7, 3'd6, 3'd2};

    function automatic logic [7:0] inv_layer_perm(input logic [7:0] x, input logic first);
        logic [23:0] idx;
        logic [7:0]  y;
        idx = first ? INV_SWAP_IDX : INV_P_IDX;
        y   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            y[i] = x[idx[3*i +: 3]];
        end
        return y;
    endfunction

endpackage

// File: rtl/dom1_and_indep.sv
// First-order DOM AND gadget on two Boolean shares; the cross-domain terms are
// refreshed with one random bit and registered before being integrated.
module dom1_and_indep (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_x1,
    input  logic i_x0,
    input  logic i_y1,
    input  logic i_y0,
    input  logic i_r,
    output logic o_z1,
    output logic o_z0
);

    logic r_c1;
    logic r_c0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c1 <= 1'b0;
            r_c0 <= 1'b0;
        end else if (i_en) begin
            r_c1 <= (i_x1 & i_y0) ^ i_r;
            r_c0 <= (i_x0 & i_y1) ^ i_r;
        end
    end

    assign o_z1 = (i_x1 & i_y1) ^ r_c1;
    assign o_z0 = (i_x0 & i_y0) ^ r_c0;

endmodule

// File: rtl/skinny_sbox8_inv_dom1_iter.sv
// Masked (DOM1) inverse SKINNY-128 8-bit S-box, one inverse layer every two
// cycles: phase 0 registers cross terms, phase 1 updates both share registers.
module skinny_sbox8_inv_dom1_iter
    import skinny_sbox_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] si_1,
    input  logic [7:0] si_0,
    input  logic [1:0] r,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] so_1,
    output logic [7:0] so_0
);

    localparam logic [1:0] LAST_LAYER = 2'(N_LAYERS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_layer;
    logic       r_phase;
    logic [7:0] r_s1;
    logic [7:0] r_s0;
    logic [7:0] r_so1;
    logic [7:0] r_so0;

    logic [7:0] w_p1;
    logic [7:0] w_p0;
    logic [1:0] w_z1;
    logic [1:0] w_z0;
    logic [7:0] w_upd1;
    logic [7:0] w_upd0;
    logic       w_en_cross;
    logic       w_last;

    assign w_p1       = inv_layer_perm(r_s1, r_layer == 2'd0);
    assign w_p0       = inv_layer_perm(r_s0, r_layer == 2'd0);
    assign w_en_cross = (r_state == ST_RUN) && !r_phase;
    assign w_last     = (r_state == ST_RUN) && r_phase && (r_layer == LAST_LAYER);

    // NOR(a,b) = ~a & ~b; the complement is applied to share 1 only.
    dom1_and_indep u_and_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_en_cross),
        .i_x1  (~w_p1[7]),
        .i_x0  (w_p0[7]),
        .i_y1  (~w_p1[6]),
        .i_y0  (w_p0[6]),
        .i_r   (r[0]),
        .o_z1  (w_z1[0]),
        .o_z0  (w_z0[0])
    );

    dom1_and_indep u_and_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_en_cross),
        .i_x1  (~w_p1[3]),
        .i_x0  (w_p0[3]),
        .i_y1  (~w_p1[2]),
        .i_y0  (w_p0[2]),
        .i_r   (r[1]),
        .o_z1  (w_z1[1]),
        .o_z0  (w_z0[1])
    );

    assign w_upd1 = w_p1 ^ {3'b000, w_z1[0], 3'b000, w_z1[1]};
    assign w_upd0 = w_p0 ^ {3'b000, w_z0[0], 3'b000, w_z0[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layer <= '0;
            r_phase <= 1'b0;
            r_s1    <= '0;
            r_s0    <= '0;
            r_so1   <= '0;
            r_so0   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_s1    <= si_1;
                        r_s0    <= si_0;
                        r_layer <= '0;
                        r_phase <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_s1    <= w_upd1;
                        r_s0    <= w_upd0;
                        r_layer <= r_layer + 2'd1;
                        if (w_last) begin
                            r_so1 <= w_upd1;
                            r_so0 <= w_upd0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign so_1      = r_so1;
    assign so_0      = r_so0;

endmodule
